operand2_decoder: RTL and testbench

Front-end for the barrelshifter in the data-processing path. Accepts a 32-bit ARM data-processing instruction word and decodes its operand-2 field: immediate rotate, immediate shift, or register-specified shift. It fetches Rm and Rs through a single register-file read port, then presents the operand, shift mode and shift count to the shifter stage behind a valid/ready handshake. It is the command producer for the shifter.

---
 rtl/operand2_decoder_pkg.sv | 39 +++
 rtl/operand2_decoder_field_decode.sv | 42 ++++
 rtl/operand2_decoder.sv | 92 +++++++++
 tb/tb_operand2_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand2_decoder_pkg.sv
// Shared shift definitions: shifter mode codes, decoder FSM states and instruction field positions.
`ifndef SHIFT_DEFS_VH
`define SHIFT_DEFS_VH
package operand2_decoder_pkg;

    localparam logic [2:0] SH_LSL = 3'b000;
    localparam logic [2:0] SH_LSR = 3'b001;
    localparam logic [2:0] SH_ASR = 3'b011;
    localparam logic [2:0] SH_ROR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ_RM = 2'd1,
        ST_READ_RS = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int unsigned F_IMM      = 25;
    localparam int unsigned F_REGSH    = 4;
    localparam int unsigned F_TYPE_LO  = 5;
    localparam int unsigned F_RM_LO    = 0;
    localparam int unsigned F_RS_LO    = 8;
    localparam int unsigned F_SHAMT_LO = 7;
    localparam int unsigned F_ROT_LO   = 8;
    localparam int unsigned F_IMM8_LO  = 0;

    typedef struct packed {
        logic       imm;
        logic [3:0] rm;
        logic [3:0] rs;
        logic       needs_rs;
        logic [2:0] mode;
        logic [4:0] count;
        logic       ext32;
        logic       rrx;
    } op2_dec_t;

endpackage
`endif

// File: rtl/operand2_decoder_field_decode.sv
// Combinational operand-2 field decode of a data-processing instruction word.
module op2_field_decode
    import operand2_decoder_pkg::*;
(
    input  logic [31:0] instr,
    output op2_dec_t    dec
);

    logic [1:0] sh_type;
    logic       unused_bits;

    assign sh_type     = instr[F_TYPE_LO +: 2];
    assign unused_bits = ^{instr[31:26], instr[24:12]};

    always_comb begin
        dec          = '0;
        dec.imm      = instr[F_IMM];
        dec.rm       = instr[F_RM_LO +: 4];
        dec.rs       = instr[F_RS_LO +: 4];
        dec.needs_rs = !instr[F_IMM] && instr[F_REGSH];
        if (instr[F_IMM]) begin
            dec.mode  = SH_ROR;
            dec.count = {instr[F_ROT_LO +: 4], 1'b0};
        end else begin
            case (sh_type)
                2'b00:   dec.mode = SH_LSL;
                2'b01:   dec.mode = SH_LSR;
                2'b10:   dec.mode = SH_ASR;
                default: dec.mode = SH_ROR;
            endcase
            // Register shifts take their count from Rs later.
            if (!instr[F_REGSH]) begin
                dec.count = instr[F_SHAMT_LO +: 5];
                if (dec.count == 5'd0) begin
                    dec.ext32 = (sh_type == 2'b01) || (sh_type == 2'b10);
                    dec.rrx   = (sh_type == 2'b11);
                end
            end
        end
    end

endmodule

// File: rtl/operand2_decoder.sv
// Operand-2 decoder: fetches Rm/Rs over one register read port and issues a shift command.
// One instruction in flight; out_valid holds until out_ready, in_ready only while idle.
module operand2_decoder
    import operand2_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        rf_req,
    output logic [3:0]  rf_addr,
    input  logic        rf_ack,
    input  logic [31:0] rf_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sh_operand,
    output logic [2:0]  sh_mode,
    output logic [4:0]  sh_count,
    output logic        sh_ext32,
    output logic        sh_rrx,
    output logic        sh_big
);

    state_t   state, state_nxt;
    op2_dec_t dec;
    logic [3:0] rm_q, rs_q;
    logic       needs_rs_q;

    op2_field_decode u_field_decode (
        .instr (instr),
        .dec   (dec)
    );

    // Handshake outputs come straight from state so reset drops them without a clock.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        rf_req    = (state == ST_READ_RM) || (state == ST_READ_RS);
        out_valid = (state == ST_DONE);
        rf_addr   = 4'd0;
        if (state == ST_READ_RM) rf_addr = rm_q;
        if (state == ST_READ_RS) rf_addr = rs_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (in_valid) state_nxt = dec.imm ? ST_DONE : ST_READ_RM;
            ST_READ_RM: if (rf_ack)   state_nxt = needs_rs_q ? ST_READ_RS : ST_DONE;
            ST_READ_RS: if (rf_ack)   state_nxt = ST_DONE;
            ST_DONE:    if (out_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rm_q       <= 4'd0;
            rs_q       <= 4'd0;
            needs_rs_q <= 1'b0;
            sh_operand <= 32'd0;
            sh_mode    <= SH_LSL;
            sh_count   <= 5'd0;
            sh_ext32   <= 1'b0;
            sh_rrx     <= 1'b0;
            sh_big     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (in_valid) begin
                    rm_q       <= dec.rm;
                    rs_q       <= dec.rs;
                    needs_rs_q <= dec.needs_rs;
                    sh_operand <= dec.imm ? {24'd0, instr[F_IMM8_LO +: 8]} : 32'd0;
                    sh_mode    <= dec.mode;
                    sh_count   <= dec.count;
                    sh_ext32   <= dec.ext32;
                    sh_rrx     <= dec.rrx;
                    sh_big     <= 1'b0;
                end
                ST_READ_RM: if (rf_ack) sh_operand <= rf_data;
                ST_READ_RS: if (rf_ack) begin
                    sh_count <= rf_data[4:0];
                    sh_big   <= |rf_data[7:5];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand2_decoder.sv
// Randomized and directed check of operand2_decoder against a behavioural model.
module tb_operand2_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'd0;
    logic        rf_req;
    logic [3:0]  rf_addr;
    logic        rf_ack = 1'b0;
    logic [31:0] rf_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sh_operand;
    logic [2:0]  sh_mode;
    logic [4:0]  sh_count;
    logic        sh_ext32, sh_rrx, sh_big;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] op;
        logic [2:0]  mode;
        logic [4:0]  cnt;
        logic        e32, rrx, big;
    } exp_t;

    operand2_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rf_req(rf_req), .rf_addr(rf_addr), .rf_ack(rf_ack), .rf_data(rf_data),
        .out_valid(out_valid), .out_ready(out_ready), .sh_operand(sh_operand),
        .sh_mode(sh_mode), .sh_count(sh_count), .sh_ext32(sh_ext32), .sh_rrx(sh_rrx),
        .sh_big(sh_big)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ARM operand-2 semantics written out arithmetically.
    function automatic exp_t model(input int unsigned ins, input int unsigned rmv, input int unsigned rsv);
        exp_t e;
        int unsigned typ, amt;
        int unsigned modes[4] = '{0, 1, 3, 5};
        e = '{op: 0, mode: 0, cnt: 0, e32: 0, rrx: 0, big: 0};
        if (((ins >> 25) & 1) == 1) begin
            e.op   = ins % 256;
            e.mode = 3'(5);
            e.cnt  = 5'(((ins >> 8) % 16) * 2);
        end else begin
            typ    = (ins >> 5) % 4;
            e.op   = rmv;
            e.mode = 3'(modes[typ]);
            if (((ins >> 4) & 1) == 1) begin
                e.cnt = 5'(rsv % 32);
                e.big = ((rsv / 32) % 8) != 0;
            end else begin
                amt   = (ins >> 7) % 32;
                e.cnt = 5'(amt);
                e.e32 = (amt == 0) && (typ == 1 || typ == 2);
                e.rrx = (amt == 0) && (typ == 3);
            end
        end
        return e;
    endfunction

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, "_operand"}, sh_operand, e.op);
        check({tag, "_mode"}, 32'(sh_mode), 32'(e.mode));
        check({tag, "_count"}, 32'(sh_count), 32'(e.cnt));
        check({tag, "_ext32"}, 32'(sh_ext32), 32'(e.e32));
        check({tag, "_rrx"}, 32'(sh_rrx), 32'(e.rrx));
        check({tag, "_big"}, 32'(sh_big), 32'(e.big));
    endtask

    // One full transaction; when pre_offered, the word is already on instr with in_valid high.
    task automatic transact(input string tag, input logic [31:0] ins, input logic [31:0] rmv,
                            input logic [31:0] rsv, input int waits, input int stall,
                            input logic offer_next, input logic [31:0] next_word,
                            input logic pre_offered);
        exp_t e;
        int lat, exp_lat, nreads;
        logic [3:0]  addrs[2];
        logic [31:0] datas[2];
        e = model(ins, rmv, rsv);
        if (!pre_offered) @(negedge clk);
        in_valid = 1'b1;
        instr    = ins;
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        instr    = $urandom;
        lat      = 1;
        nreads   = ins[25] ? 0 : (ins[4] ? 2 : 1);
        addrs[0] = ins[3:0];   datas[0] = rmv;
        addrs[1] = ins[11:8];  datas[1] = rsv;
        for (int r = 0; r < nreads; r++) begin
            for (int w = 0; w <= waits; w++) begin
                check({tag, "_rf_req"}, 32'(rf_req), 32'd1);
                check({tag, "_rf_addr"}, 32'(rf_addr), 32'(addrs[r]));
                check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
                rf_ack  = (w == waits);
                rf_data = (w == waits) ? datas[r] : $urandom;
                @(negedge clk);
                lat++;
                rf_ack = 1'b0;
            end
        end
        for (int k = 0; k < 8 && !out_valid; k++) begin
            @(negedge clk);
            lat++;
        end
        exp_lat = ins[25] ? 1 : (ins[4] ? 3 + 2 * waits : 2 + waits);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rf_req_done"}, 32'(rf_req), 32'd0);
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        check_outs(tag, e);
        if (offer_next) begin
            in_valid = 1'b1;
            instr    = next_word;
        end
        for (int s = 0; s < stall; s++) begin
            rf_ack  = $urandom_range(0, 1) == 1;
            rf_data = $urandom;
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_stall_operand"}, sh_operand, e.op);
            check({tag, "_stall_count"}, 32'(sh_count), 32'(e.cnt));
        end
        rf_ack    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] mk_imm(input int unsigned rot, input int unsigned imm8);
        return 32'h02A00000 | 32'(rot << 8) | 32'(imm8);
    endfunction
    function automatic logic [31:0] mk_sh(input int unsigned rm, input int unsigned typ, input int unsigned amt);
        return 32'h01A00000 | 32'(amt << 7) | 32'(typ << 5) | 32'(rm);
    endfunction
    function automatic logic [31:0] mk_rs(input int unsigned rm, input int unsigned typ, input int unsigned rs);
        return 32'h01A00010 | 32'(rs << 8) | 32'(typ << 5) | 32'(rm);
    endfunction

    initial begin
        exp_t zero;
        logic [31:0] w;
        zero = '{op: 0, mode: 0, cnt: 0, e32: 0, rrx: 0, big: 0};

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_rf_req", 32'(rf_req), 32'd0);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_outs("rst", zero);
        @(negedge clk);
        rst_n = 1'b1;

        transact("imm_ff", 32'h02A000FF, 0, 0, 0, 0, 1'b0, 0, 1'b0);
        transact("imm_rot4", mk_imm(4, 8'h3F), 0, 0, 0, 0, 1'b0, 0, 1'b0);
        transact("lsr0", mk_sh(2, 1, 0), 32'h80000000, 0, 2, 0, 1'b0, 0, 1'b0);
        transact("asr0", mk_sh(7, 2, 0), 32'h0F0F0F0F, 0, 0, 0, 1'b0, 0, 1'b0);
        transact("rrx", mk_sh(9, 3, 0), 32'hCAFEF00D, 0, 1, 0, 1'b0, 0, 1'b0);
        transact("lsl0", mk_sh(4, 0, 0), 32'h00000011, 0, 0, 0, 1'b0, 0, 1'b0);
        transact("regsh", mk_rs(1, 2, 3), 32'h12345678, 32'h00000124, 0, 0, 1'b0, 0, 1'b0);
        transact("stall", mk_imm(1, 8'hA5), 0, 0, 0, 5, 1'b1, mk_sh(5, 0, 3), 1'b0);
        transact("second", mk_sh(5, 0, 3), 32'hDEADBEEF, 0, 0, 0, 1'b0, 0, 1'b1);

        // Abort during the Rs read.
        @(negedge clk);
        in_valid = 1'b1;
        instr    = mk_rs(6, 1, 12);
        @(negedge clk);
        in_valid = 1'b0;
        rf_ack   = 1'b1;
        rf_data  = 32'h55AA55AA;
        @(negedge clk);
        rf_ack = 1'b0;
        check("abort_pre_rf_req", 32'(rf_req), 32'd1);
        check("abort_pre_rf_addr", 32'(rf_addr), 32'd12);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rf_req", 32'(rf_req), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_rf_addr", 32'(rf_addr), 32'd0);
        check_outs("abort", zero);
        @(negedge clk);
        rst_n = 1'b1;
        transact("after_abort", mk_rs(3, 3, 2), 32'h80000001, 32'h0000001F, 1, 0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            transact("rand", w, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                     1'b0, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
